// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one pipelined Sigmoid unit among N_REQ requesters.
// Each requester owns a slot tracking its single outstanding operation.
//
// state    | meaning
// IDLE     | no operation; eligible for grant while req_valid is high
// INFLIGHT | operand issued to the Sigmoid, result not yet captured
// DONE     | result held in rsp_data, waiting for rsp_ready
module sigmoid_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [16*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [16*N_REQ-1:0] rsp_data,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [15:0]         sig_in,
  input  logic [15:0]         sig_out,
  output logic                busy,
  output logic [2:0]          grant_id
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } slot_t;

  slot_t            slot     [N_REQ];
  slot_t            slot_nxt [N_REQ];
  logic [2:0]       ptr;
  logic             tag_vld  [LAT];
  logic [2:0]       tag_idx  [LAT];
  logic [N_REQ-1:0] elig;
  logic             gnt_any;
  logic [2:0]       gnt_idx;
  logic             cap_vld;
  logic [2:0]       cap_idx;

  assign cap_vld  = tag_vld[LAT-1];
  assign cap_idx  = tag_idx[LAT-1];
  assign grant_id = gnt_idx;

  // Two passes give the wrap-around search: indices at or above ptr first, then the rest.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (slot[i] == IDLE);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && elig[i] && (3'(i) >= ptr)) begin
        gnt_any = 1'b1;
        gnt_idx = 3'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && elig[i]) begin
        gnt_any = 1'b1;
        gnt_idx = 3'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sig_in    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_any && (gnt_idx == 3'(i))) begin
        req_ready[i] = 1'b1;
        sig_in       = req_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      slot_nxt[i]  = slot[i];
      rsp_valid[i] = (slot[i] == DONE);
      busy         = busy | (slot[i] != IDLE);
      case (slot[i])
        IDLE:     if (req_ready[i]) slot_nxt[i] = INFLIGHT;
        INFLIGHT: if (cap_vld && (cap_idx == 3'(i))) slot_nxt[i] = DONE;
        DONE:     if (rsp_ready[i]) slot_nxt[i] = IDLE;
        default:  slot_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        slot[i] <= IDLE;
      end
      ptr <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_vld[s] <= 1'b0;
        tag_idx[s] <= '0;
      end
      rsp_data <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        slot[i] <= slot_nxt[i];
      end
      if (gnt_any) begin
        ptr <= (gnt_idx == 3'(N_REQ-1)) ? 3'd0 : gnt_idx + 3'd1;
      end
      // Tag pipeline mirrors the Sigmoid latency so each result finds its owner.
      tag_vld[0] <= gnt_any;
      tag_idx[0] <= gnt_idx;
      for (int s = 1; s < LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (cap_vld && (cap_idx == 3'(i))) begin
          rsp_data[16*i +: 16] <= sig_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Scoreboard bench for sigmoid_arbiter: a behavioural slot/round-robin model predicts
// grants, and a separate monitor pops expected results as responses appear.
module tb_sigmoid_arbiter;
  localparam int N   = 4;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0]    rsp_ready = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [16*N-1:0] rsp_data;
  logic [15:0]     sig_in;
  logic [15:0]     sig_out;
  logic            busy;
  logic [2:0]      grant_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sigmoid_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .sig_in(sig_in), .sig_out(sig_out), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sigm(input logic [15:0] x);
    real r;
    r = 256.0 / (1.0 + $exp(-$itor($signed(x)) / 256.0));
    return 16'($rtoi(r + 0.5));
  endfunction

  // Shared Sigmoid instance: LAT-cycle pipeline
  logic [15:0] spipe [LAT];
  always @(posedge clk) begin
    spipe[0] <= sigm(sig_in);
    for (int s = 1; s < LAT; s++) spipe[s] <= spipe[s-1];
  end
  assign sig_out = spipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got nothing expected an event (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb [$];

  // Reference model: a requester is either free or has one operation outstanding.
  bit           outst [N];
  int           gcyc  [N];
  int           ptr_m = 0;
  int           m_g;
  logic [N-1:0] m_ready;
  logic [N-1:0] m_rv;
  logic [15:0]  m_sig;
  logic         m_busy;
  exp_t         m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) outst[i] = 1'b0;
      ptr_m = 0;
      sb.delete();
      check("reset_rsp_valid", rsp_valid, '0);
      check("reset_busy", busy, 0);
      check("reset_sig_in", sig_in, 0);
      check("reset_req_ready", req_ready, 0);
    end else begin
      m_g = -1;
      for (int k = 0; k < N; k++)
        if (m_g < 0 && req_valid[(ptr_m + k) % N] && !outst[(ptr_m + k) % N]) m_g = (ptr_m + k) % N;
      m_ready = '0;
      m_sig   = '0;
      if (m_g >= 0) begin
        m_ready[m_g] = 1'b1;
        m_sig = req_data[16*m_g +: 16];
      end
      m_rv   = '0;
      m_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_rv[i] = outst[i] && (cyc >= gcyc[i] + LAT + 1);
        m_busy  = m_busy | outst[i];
      end
      check("req_ready", req_ready, m_ready);
      check("sig_in", sig_in, m_sig);
      if (m_g >= 0) check("grant_id", grant_id, m_g);
      check("rsp_valid", rsp_valid, m_rv);
      check("busy", busy, m_busy);
      for (int i = 0; i < N; i++) if (m_rv[i] && rsp_ready[i]) outst[i] = 1'b0;
      if (m_g >= 0) begin
        outst[m_g] = 1'b1;
        gcyc[m_g]  = cyc;
        m_e.idx  = m_g;
        m_e.data = sigm(m_sig);
        m_e.due  = cyc + LAT + 1;
        sb.push_back(m_e);
        ptr_m = (m_g + 1) % N;
      end
    end
  end

  // Monitor: compares presented results against the scoreboard
  logic [N-1:0] mon_prev = '0;
  int           mon_pos;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          mon_pos = -1;
          for (int q = 0; q < sb.size(); q++) if (mon_pos < 0 && sb[q].idx == i) mon_pos = q;
          if (mon_pos < 0) begin
            fail_now("rsp_without_request");
          end else begin
            check("rsp_data", rsp_data[16*i +: 16], sb[mon_pos].data);
            if (!mon_prev[i]) check("rsp_latency", cyc, sb[mon_pos].due);
            if (rsp_ready[i]) sb.delete(mon_pos);
          end
        end
      end
      mon_prev = rsp_valid;
    end else begin
      mon_prev = '0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle_drain(input int n);
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = '1;
    repeat (n) @(posedge clk);
  endtask

  task automatic single(input int idx, input logic [15:0] d, input logic [15:0] exp);
    int n;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_data[16*idx +: 16] = d;
    rsp_ready = '1;
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (!rsp_valid[idx] && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[idx]) begin
      fail_now("single_timeout");
    end else begin
      check("single_latency", n, LAT + 1);
      check("single_data", rsp_data[16*idx +: 16], exp);
    end
    @(negedge clk);
    check("single_idle_busy", busy, 0);
    check("single_idle_rsp_valid", rsp_valid[idx], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    int tot;
    logic [15:0] d;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    single(0, 16'h0000, 16'h0080);
    single(1, 16'h0100, 16'h00BB);
    single(1, 16'hFF00, 16'h0045);
    single(1, 16'h0700, 16'h0100);

    // Accept and new request on the same index in one cycle
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data[15:0] = 16'h0100;
    rsp_ready = '0;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'b0001;
    rsp_ready = 4'b0001;
    @(negedge clk);
    check("accept_cycle_ready0", req_ready[0], 0);
    check("accept_cycle_rsp_valid0", rsp_valid[0], 1);
    @(negedge clk);
    check("regrant_next_cycle", req_ready[0], 1);
    idle_drain(6);

    // Full round after reset
    do_reset();
    @(posedge clk); #1;
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) req_data[16*i +: 16] = 16'(i * 16'h0040);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("rr_order", grant_id, k);
    end
    idle_drain(8);

    // Stalled response on requester 1
    @(posedge clk); #1;
    req_valid = '1;
    rsp_ready = 4'b1101;
    for (int i = 0; i < N; i++) req_data[16*i +: 16] = 16'($urandom);
    n1 = 0;
    tot = 0;
    repeat (30) begin
      @(negedge clk);
      if (req_ready[1]) n1++;
      if (|req_ready) tot++;
    end
    check("stall_grants_to_1", n1, 1);
    check("stall_others_rotate", (tot >= 20), 1);
    idle_drain(6);

    // Reset while requester 2 is in flight
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data[47:32] = 16'h0200;
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_rsp_valid2", rsp_valid[2], 0);
    @(posedge clk); #1;
    req_valid = 4'b0110;
    @(negedge clk);
    check("post_reset_lowest_grant", grant_id, 1);
    check("post_reset_ready", req_ready, 4'b0010);
    idle_drain(6);

    // Randomized traffic
    repeat (1500) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom);
      rsp_ready = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < N; i++) begin
        d = 16'($urandom);
        if ($urandom_range(0, 3) == 0) d = 16'($signed(d) >>> 5);
        req_data[16*i +: 16] = d;
      end
    end
    idle_drain(10);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
